// File: rtl/sgd_sequencer_if.sv
// Control bundle between the SGD sequencer and the fetch unit / three-stage datapath.
// The sequencer takes the slave side; the fetch/datapath block takes the master side.
interface sgd_sequencer_if #(
  parameter int logNumCycle = 2
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   sel;
  logic                   last_chunk;
  logic                   grad_en;
  logic                   wb_valid;
  logic [logNumCycle-1:0] wb_idx;

  modport master (
    output in_valid,
    input  in_ready, sel, last_chunk, grad_en, wb_valid, wb_idx
  );

  modport slave (
    input  in_valid,
    output in_ready, sel, last_chunk, grad_en, wb_valid, wb_idx
  );
endinterface

// File: rtl/sgd_sequencer.sv
// Sequencer for the Axiline SGD datapath: counts chunks/samples/epochs, steers the ip
// accumulate select and gradient enable, and tracks the weight write-back through a delay line.
module sgd_sequencer #(
  parameter int NumCycle    = 4,
  parameter int logNumCycle = 2,
  parameter int cntBitwidth = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [cntBitwidth-1:0] num_samples,
  input  logic [cntBitwidth-1:0] num_epochs,
  sgd_sequencer_if.slave         bus,
  output logic                   busy,
  output logic                   done,
  output logic                   err_stall
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  typedef struct packed {
    logic                   valid;
    logic [logNumCycle-1:0] idx;
  } wb_slot_t;

  localparam int                     Depth     = NumCycle + 2;
  localparam logic [logNumCycle-1:0] LastChunk = logNumCycle'(NumCycle - 1);
  localparam logic [cntBitwidth-1:0] One       = cntBitwidth'(1);

  state_e                 state_q, state_d;
  logic [logNumCycle-1:0] chunk_q;
  logic [cntBitwidth-1:0] sample_q, epoch_q;
  logic [cntBitwidth-1:0] cfg_samples_q, cfg_epochs_q;
  logic                   grad_en_q;
  wb_slot_t               wb_line_q [Depth];

  logic beat, sample_end, last_sample, last_epoch, run_end, line_empty;

  assign bus.in_ready = (state_q == RUN);
  assign beat         = bus.in_valid & bus.in_ready;
  assign sample_end   = beat & (chunk_q == LastChunk);
  assign last_sample  = (sample_q == cfg_samples_q - One);
  assign last_epoch   = (epoch_q == cfg_epochs_q - One);
  assign run_end      = sample_end & last_sample & last_epoch;

  assign bus.sel        = beat & (chunk_q != '0);
  assign bus.last_chunk = sample_end;
  assign bus.grad_en    = grad_en_q;
  assign bus.wb_valid   = wb_line_q[Depth-1].valid;
  assign bus.wb_idx     = wb_line_q[Depth-1].idx;
  assign busy           = (state_q == RUN) || (state_q == DRAIN);
  assign done           = (state_q == DONE);

  always_comb begin
    line_empty = 1'b1;
    for (int i = 0; i < Depth; i++) begin
      if (wb_line_q[i].valid) line_empty = 1'b0;
    end
  end

  // NOTE: state_d is defaulted before the case so no branch can leave it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)      state_d = RUN;
      RUN:     if (run_end)    state_d = DRAIN;
      DRAIN:   if (line_empty) state_d = DONE;
      DONE:                    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // NOTE: all registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chunk_q       <= '0;
      sample_q      <= '0;
      epoch_q       <= '0;
      cfg_samples_q <= One;
      cfg_epochs_q  <= One;
      err_stall     <= 1'b0;
    end else if (state_q == IDLE) begin
      if (start) begin
        cfg_samples_q <= (num_samples == '0) ? One : num_samples;
        cfg_epochs_q  <= (num_epochs == '0) ? One : num_epochs;
        chunk_q       <= '0;
        sample_q      <= '0;
        epoch_q       <= '0;
        err_stall     <= 1'b0;
      end
    end else if (state_q == RUN) begin
      if (beat) begin
        if (chunk_q == LastChunk) begin
          chunk_q <= '0;
          if (last_sample) begin
            sample_q <= '0;
            epoch_q  <= last_epoch ? '0 : epoch_q + One;
          end else begin
            sample_q <= sample_q + One;
          end
        end else begin
          chunk_q <= chunk_q + 1'b1;
        end
      end else if (chunk_q != '0) begin
        // A mid-sample gap breaks the ip pipe alignment; flag it and hold position.
        err_stall <= 1'b1;
      end
    end
  end

  // NOTE: the delay line is reset, unlike a data RAM, because its valid bits drive wb_valid directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grad_en_q <= 1'b0;
      for (int i = 0; i < Depth; i++) wb_line_q[i] <= '0;
    end else begin
      grad_en_q    <= sample_end;
      wb_line_q[0] <= '{valid: beat, idx: beat ? chunk_q : '0};
      for (int i = 1; i < Depth; i++) wb_line_q[i] <= wb_line_q[i-1];
    end
  end

endmodule

// File: tb/tb_sgd_sequencer.sv
// Scoreboard bench for sgd_sequencer: beats push expected grad_en / write-back events,
// a negedge monitor pops and compares them, and each run checks done latency and error flag.
module tb_sgd_sequencer;

  localparam int NC = 4;
  localparam int D  = NC + 2;

  typedef struct {
    int due;
    int idx;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_samples = '0;
  logic [15:0] num_epochs = '0;
  logic        busy, done, err_stall;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_beat_cyc = 0;
  wb_t wb_q[$];
  int  grad_q[$];

  sgd_sequencer_if #(.logNumCycle(2)) bus ();

  sgd_sequencer #(.NumCycle(NC), .logNumCycle(2), .cntBitwidth(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .num_epochs  (num_epochs),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .err_stall   (err_stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: registered outputs sampled on the falling edge.
  always @(negedge clk) begin
    wb_t e;
    if (rst) begin
      if (bus.wb_valid) begin
        if (wb_q.size() == 0) check("wb_extra", 1, 0);
        else begin
          e = wb_q.pop_front();
          check("wb_cyc", cyc, e.due);
          check("wb_idx", bus.wb_idx, e.idx);
        end
      end else if (wb_q.size() > 0 && wb_q[0].due <= cyc) begin
        check("wb_miss", 0, 1);
        void'(wb_q.pop_front());
      end
      if (bus.grad_en) begin
        if (grad_q.size() == 0) check("grad_extra", 1, 0);
        else check("grad_cyc", cyc, grad_q.pop_front());
      end else if (grad_q.size() > 0 && grad_q[0] <= cyc) begin
        check("grad_miss", 0, 1);
        void'(grad_q.pop_front());
      end
    end
  end

  task automatic start_run(input int ns, input int ne);
    @(negedge clk);
    num_samples = 16'(ns);
    num_epochs  = 16'(ne);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_run", busy, 1);
    check("err_cleared", err_stall, 0);
  endtask

  task automatic drive_beat(input int chunk, input bit poke_start);
    bus.in_valid = 1'b1;
    if (poke_start) begin
      start = 1'b1;
      num_samples = 16'd7;
      num_epochs  = 16'd7;
    end
    #1;
    check("in_ready", bus.in_ready, 1);
    check("sel", bus.sel, (chunk != 0) ? 1 : 0);
    check("last_chunk", bus.last_chunk, (chunk == NC - 1) ? 1 : 0);
    wb_q.push_back('{due: cyc + D, idx: chunk});
    if (chunk == NC - 1) grad_q.push_back(cyc + 1);
    last_beat_cyc = cyc;
    @(negedge clk);
    bus.in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic idle_cycle();
    bus.in_valid = 1'b0;
    #1;
    check("idle_sel", bus.sel, 0);
    check("idle_last", bus.last_chunk, 0);
    @(negedge clk);
  endtask

  task automatic wait_done(input int exp_cyc);
    int n = 0;
    check("drain_ready", bus.in_ready, 0);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
    check("done_cyc", cyc, exp_cyc);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("busy_idle", busy, 0);
    check("wbq_empty", wb_q.size(), 0);
    check("gradq_empty", grad_q.size(), 0);
  endtask

  task automatic do_run(input int ns, input int ne, input int gap_sample, input int gap_len,
                        input int stall_at, input bit start_mid, input bit abort);
    int eff_s = (ns == 0) ? 1 : ns;
    int eff_e = (ne == 0) ? 1 : ne;
    int beats = eff_s * eff_e * NC;
    start_run(ns, ne);
    for (int b = 0; b < beats; b++) begin
      if (b == stall_at) begin
        idle_cycle();
        check("err_set", err_stall, 1);
      end
      drive_beat(b % NC, start_mid && b == 1);
      if (b % NC == NC - 1 && b / NC == gap_sample) begin
        for (int g = 0; g < gap_len; g++) begin
          idle_cycle();
          check("gap_no_err", err_stall, 0);
        end
      end
    end
    if (abort) begin
      @(negedge clk);
      check("abort_in_drain", busy, 1);
      #3 rst = 1'b0;
      #1;
      check("rst_ready", bus.in_ready, 0);
      check("rst_sel", bus.sel, 0);
      check("rst_last", bus.last_chunk, 0);
      check("rst_grad", bus.grad_en, 0);
      check("rst_wbv", bus.wb_valid, 0);
      check("rst_wbidx", bus.wb_idx, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err_stall, 0);
      wb_q.delete();
      grad_q.delete();
      @(negedge clk);
      rst = 1'b1;
      repeat (D + 2) @(negedge clk);
      check("post_rst_wbv", bus.wb_valid, 0);
      check("post_rst_busy", busy, 0);
    end else begin
      wait_done(last_beat_cyc + NC + 4);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    #1;
    check("reset_ready", bus.in_ready, 0);
    check("reset_wbv", bus.wb_valid, 0);
    check("reset_wbidx", bus.wb_idx, 0);
    check("reset_grad", bus.grad_en, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err_stall, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    do_run(1, 1, -1, 0, -1, 1'b0, 1'b0);   // T1: single sample
    do_run(3, 2, -1, 0, -1, 1'b0, 1'b0);   // T2: 24 continuous beats
    do_run(3, 1, 1, 2, -1, 1'b0, 1'b0);    // T3: legal inter-sample gap
    do_run(2, 1, -1, 0, 2, 1'b0, 1'b0);    // T4: stall at chunk 2
    check("err_sticky", err_stall, 1);
    do_run(1, 1, -1, 0, -1, 1'b1, 1'b0);   // T5a: start ignored mid-run
    do_run(1, 1, -1, 0, -1, 1'b0, 1'b1);   // T5b: reset during DRAIN
    do_run(0, 0, -1, 0, -1, 1'b0, 1'b0);   // T6: zero config treated as 1/1

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 want 1");
    $fatal(1, "timeout");
  end

endmodule
